// File: rtl/alu_div_sequencer_if.sv
// Request/result bundle between the EX stage (master) and the divide sequencer (slave).
// The div_by_zero signal exists only when DIV_ZERO_TRAP_EN is defined.
interface alu_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_TRAP_EN
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder
    );
    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder
    );
`endif
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle DIV/DIVU restoring divider that borrows an external alu for its subtracts.
// Optional feature macro: DIV_ZERO_TRAP_EN (short-circuits divide-by-zero, adds div_by_zero).
module alu_div_sequencer #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] ALUC_SUBU = 4'b0001,
    parameter logic [3:0] ALUC_IDLE = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_div_sequencer_if.slave    bus,
    output logic [WIDTH-1:0]      alu_a_o,
    output logic [WIDTH-1:0]      alu_b_o,
    output logic [3:0]            alu_aluc_o,
    input  logic [WIDTH-1:0]      alu_r_i,
    input  logic                  alu_carry_i
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_aluc_q, alu_aluc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_TRAP_EN
    logic             dz_q, dz_d;
    logic             div_by_zero_q, div_by_zero_d;
`endif

    logic             dd_neg_s;
    logic             dv_neg_s;
    logic [WIDTH-1:0] dd_mag_s;
    logic [WIDTH-1:0] dv_mag_s;
    logic             ok_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        alu_b_d     = alu_b_q;
        alu_a_d     = {WIDTH{1'b0}};
        alu_aluc_d  = ALUC_IDLE;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_TRAP_EN
        dz_d          = dz_q;
        div_by_zero_d = 1'b0;
`endif

        dd_neg_s = bus.is_signed & bus.dividend[WIDTH-1];
        dv_neg_s = bus.is_signed & bus.divisor[WIDTH-1];
        dd_mag_s = dd_neg_s ? neg2(bus.dividend) : bus.dividend;
        dv_mag_s = dv_neg_s ? neg2(bus.divisor) : bus.divisor;
        // A set top bit means P really has WIDTH+1 bits, so it always exceeds the divisor.
        ok_s     = rem_q[WIDTH-1] | ~alu_carry_i;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    q_neg_d = dd_neg_s ^ dv_neg_s;
                    r_neg_d = dd_neg_s;
                    rem_d   = {WIDTH{1'b0}};
                    quo_d   = dd_mag_s;
                    alu_b_d = dv_mag_s;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_ITER;
`ifdef DIV_ZERO_TRAP_EN
                    dz_d = 1'b0;
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = bus.dividend;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        dz_d    = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        dz_d = 1'b0;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = ok_s ? alu_r_i : alu_a_q;
                    quo_d = {quo_q[WIDTH-2:0], ok_s};
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    quotient_d  = q_neg_q ? neg2(quo_q) : quo_q;
                    remainder_d = r_neg_q ? neg2(rem_q) : rem_q;
`ifdef DIV_ZERO_TRAP_EN
                    div_by_zero_d = dz_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The alu operands are pre-computed for the coming cycle and held at zero otherwise.
        if (state_d == S_ITER) begin
            alu_a_d    = {rem_d[WIDTH-2:0], quo_d[WIDTH-1]};
            alu_aluc_d = ALUC_SUBU;
        end else begin
            alu_a_d    = {WIDTH{1'b0}};
            alu_b_d    = {WIDTH{1'b0}};
            alu_aluc_d = ALUC_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            alu_a_q     <= {WIDTH{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_aluc_q  <= ALUC_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
`ifdef DIV_ZERO_TRAP_EN
            dz_q          <= 1'b0;
            div_by_zero_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_aluc_q  <= alu_aluc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_TRAP_EN
            dz_q          <= dz_d;
            div_by_zero_q <= div_by_zero_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
`ifdef DIV_ZERO_TRAP_EN
    assign bus.div_by_zero = div_by_zero_q;
`endif
    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_aluc_o = alu_aluc_q;

endmodule
